// File: rtl/i2s_tx_tdm_pkg.sv
// Shared types and widths for the multi-lane TDM I2S transmitter.
package i2s_tx_tdm_pkg;

   localparam int OFFSET_W = 9;

   typedef enum logic [2:0] {
      IDLE,
      PRELOAD,
      WAIT_FS,
      OFFSET,
      RUN
   } state_t;

   // Configuration fields must be at least one bit wide, even for a single lane.
   function automatic int min_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2s_tx_tdm_channel_if.sv
// TX FIFO word handshake between the uDMA FIFO (master) and the transmitter (slave).
interface i2s_tx_tdm_channel_if #(
   parameter int DW = 32
);

   logic [DW-1:0] data;
   logic          valid;
   logic          ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );

endinterface

// File: rtl/i2s_tx_lane_shifter.sv
// One serial lane: shadow word filled from the FIFO, shift word being sent, registered sd.
module i2s_tx_lane_shifter #(
   parameter int DW    = 32,
   parameter int BIT_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clear,
   input  logic             active,
   input  logic             wr_en,
   input  logic [DW-1:0]    wr_data,
   input  logic             load,
   input  logic             zero_load,
   input  logic             shift,
   input  logic [BIT_W-1:0] bit_idx,
   output logic             sd
);

   logic [DW-1:0] shadow;
   logic [DW-1:0] shift_reg;

   // The first bit of a slot comes straight from the shadow so it lands on the slot boundary.
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         shadow    <= '0;
         shift_reg <= '0;
         sd        <= 1'b0;
      end else begin
         if (wr_en) begin
            shadow <= wr_data;
         end
         if (load) begin
            shift_reg <= shadow;
            sd        <= active & shadow[bit_idx];
         end else if (zero_load) begin
            shift_reg <= '0;
            sd        <= 1'b0;
         end else if (shift) begin
            sd <= active & shift_reg[bit_idx];
         end else begin
            sd <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/i2s_tx_tdm_channel.sv
// Multi-lane, multi-slot TDM/DSP-mode I2S transmitter on the sck domain.
// Optional per-slot masking is built in when I2S_TX_SLOT_MASK_EN is defined.
module i2s_tx_tdm_channel
   import i2s_tx_tdm_pkg::*;
#(
   parameter  int NUM_LANES = 2,
   parameter  int NUM_SLOTS = 8,
   parameter  int DW        = 32,
   localparam int LANE_W    = min_width(NUM_LANES),
   localparam int SLOT_W    = min_width(NUM_SLOTS),
   localparam int BIT_W     = min_width(DW)
) (
   input  logic                 sck_i,
   input  logic                 rstn_i,
   input  logic                 ws_i,
   output logic [NUM_LANES-1:0] sd_o,
   i2s_tx_tdm_channel_if.slave  fifo,
   output logic                 ready_to_send_o,
   output logic                 underrun_o,
   input  logic                 cfg_en_i,
   input  logic [BIT_W-1:0]     cfg_num_bits_i,
   input  logic [SLOT_W-1:0]    cfg_num_slots_i,
   input  logic [LANE_W-1:0]    cfg_num_lanes_i,
`ifdef I2S_TX_SLOT_MASK_EN
   input  logic [NUM_SLOTS-1:0] cfg_slot_mask_i,
`endif
   input  logic                 cfg_lsb_first_i,
   input  logic [OFFSET_W-1:0]  cfg_offset_i
);

   localparam int FILL_W = LANE_W + 1;

   state_t              state;
   logic [FILL_W-1:0]   fill_ptr;
   logic [BIT_W-1:0]    bit_cnt;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [OFFSET_W-1:0] off_cnt;

   logic                shadows_full;
   logic                fifo_fire;
   logic                last_bit;
   logic                last_slot;
   logic                frame_end;
   logic                frame_go;
   logic                run_start;
   logic                slot_start;
   logic [SLOT_W-1:0]   start_slot;
   logic                slot_on;
   logic                load;
   logic                zero_load;
   logic                shift;
   logic [BIT_W-1:0]    next_cnt;
   logic [BIT_W-1:0]    bit_idx;

   assign shadows_full = fill_ptr > {1'b0, cfg_num_lanes_i};
   assign fifo.ready   = (state != IDLE) && (fill_ptr <= {1'b0, cfg_num_lanes_i});
   assign fifo_fire    = fifo.valid && fifo.ready;

   // A frame sync on the very last bit chains the next frame with no idle bit.
   assign last_bit   = (state == RUN) && (bit_cnt == cfg_num_bits_i);
   assign last_slot  = (slot_cnt == cfg_num_slots_i);
   assign frame_end  = last_bit && last_slot;
   assign frame_go   = ws_i && ((state == WAIT_FS) || frame_end);
   assign run_start  = (frame_go && (cfg_offset_i == '0)) || ((state == OFFSET) && (off_cnt == '0));
   assign slot_start = run_start || (last_bit && !last_slot);
   assign start_slot = run_start ? '0 : slot_cnt + SLOT_W'(1);

`ifdef I2S_TX_SLOT_MASK_EN
   assign slot_on = cfg_slot_mask_i[start_slot];
`else
   assign slot_on = 1'b1;
`endif

   // An incomplete set of shadows sends a zero slot but keeps the partial words for the next one.
   assign load      = slot_start && slot_on && shadows_full;
   assign zero_load = slot_start && !load;
   assign shift     = (state == RUN) && !last_bit;
   assign next_cnt  = slot_start ? '0 : bit_cnt + BIT_W'(1);
   assign bit_idx   = cfg_lsb_first_i ? next_cnt : cfg_num_bits_i - next_cnt;

   // Frame sequencing, counters and fill pointer; status outputs are registered here too.
   always_ff @(posedge sck_i) begin
      if (!rstn_i || !cfg_en_i) begin
         state           <= IDLE;
         fill_ptr        <= '0;
         bit_cnt         <= '0;
         slot_cnt        <= '0;
         off_cnt         <= '0;
         underrun_o      <= 1'b0;
         ready_to_send_o <= 1'b0;
      end else begin
         underrun_o <= slot_start && slot_on && !shadows_full;

         if (load) begin
            fill_ptr <= '0;
         end else if (fifo_fire) begin
            fill_ptr <= fill_ptr + FILL_W'(1);
         end

         if (slot_start) begin
            bit_cnt  <= '0;
            slot_cnt <= start_slot;
         end else if (shift) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
         end

         case (state)
            IDLE: begin
               state <= PRELOAD;
            end
            PRELOAD: begin
               if (shadows_full) begin
                  state           <= WAIT_FS;
                  ready_to_send_o <= 1'b1;
               end
            end
            WAIT_FS, RUN: begin
               if (frame_go) begin
                  if (cfg_offset_i == '0) begin
                     state <= RUN;
                  end else begin
                     state   <= OFFSET;
                     off_cnt <= cfg_offset_i - OFFSET_W'(1);
                  end
               end else if (frame_end) begin
                  state <= WAIT_FS;
               end
            end
            OFFSET: begin
               if (off_cnt == '0) begin
                  state <= RUN;
               end else begin
                  off_cnt <= off_cnt - OFFSET_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      i2s_tx_lane_shifter #(
         .DW    (DW),
         .BIT_W (BIT_W)
      ) u_lane (
         .clk       (sck_i),
         .rstn      (rstn_i),
         .clear     (!cfg_en_i),
         .active    (FILL_W'(l) <= {1'b0, cfg_num_lanes_i}),
         .wr_en     (fifo_fire && (fill_ptr == FILL_W'(l))),
         .wr_data   (fifo.data),
         .load      (load),
         .zero_load (zero_load),
         .shift     (shift),
         .bit_idx   (bit_idx),
         .sd        (sd_o[l])
      );
   end

endmodule

// File: tb/tb_i2s_tx_tdm_channel.sv
// Scoreboard bench for i2s_tx_tdm_channel: FIFO words queued as stimulus, expected slot words compared per lane.
module tb_i2s_tx_tdm_channel;

   localparam int NUM_LANES = 2;
   localparam int NUM_SLOTS = 8;
   localparam int DW        = 32;
   localparam int LANE_W    = 1;
   localparam int SLOT_W    = 3;
   localparam int BIT_W     = 5;

   typedef struct packed {
      logic [NUM_LANES-1:0][DW-1:0] words;
      logic                         underrun;
   } slot_t;

   logic                 clk;
   logic                 rstn;
   logic                 ws;
   logic [NUM_LANES-1:0] sd;
   logic                 ready_to_send;
   logic                 underrun;
   logic                 cfg_en;
   logic [BIT_W-1:0]     cfg_num_bits;
   logic [SLOT_W-1:0]    cfg_num_slots;
   logic [LANE_W-1:0]    cfg_num_lanes;
   logic                 cfg_lsb_first;
   logic [8:0]           cfg_offset;
`ifdef I2S_TX_SLOT_MASK_EN
   logic [NUM_SLOTS-1:0] slot_mask;
`endif

   logic [DW-1:0] feed_q[$];
   slot_t         exp_q[$];
   logic          stall;
   int            n_checks = 0;
   int            n_pass   = 0;

   i2s_tx_tdm_channel_if #(.DW(DW)) fifo_if ();

   i2s_tx_tdm_channel #(
      .NUM_LANES (NUM_LANES),
      .NUM_SLOTS (NUM_SLOTS),
      .DW        (DW)
   ) dut (
      .sck_i           (clk),
      .rstn_i          (rstn),
      .ws_i            (ws),
      .sd_o            (sd),
      .fifo            (fifo_if),
      .ready_to_send_o (ready_to_send),
      .underrun_o      (underrun),
      .cfg_en_i        (cfg_en),
      .cfg_num_bits_i  (cfg_num_bits),
      .cfg_num_slots_i (cfg_num_slots),
      .cfg_num_lanes_i (cfg_num_lanes),
`ifdef I2S_TX_SLOT_MASK_EN
      .cfg_slot_mask_i (slot_mask),
`endif
      .cfg_lsb_first_i (cfg_lsb_first),
      .cfg_offset_i    (cfg_offset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // FIFO model: a word leaves the queue once valid and ready were both high across a posedge.
   initial begin
      bit fire_flag;
      fire_flag     = 1'b0;
      fifo_if.valid = 1'b0;
      fifo_if.data  = '0;
      forever begin
         @(negedge clk);
         if (fire_flag && feed_q.size() > 0) void'(feed_q.pop_front());
         fifo_if.valid = !stall && (feed_q.size() > 0);
         fifo_if.data  = (feed_q.size() > 0) ? feed_q[0] : '0;
         fire_flag     = fifo_if.valid && fifo_if.ready;
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic applyStimulus(input int lanes, input int slots, input int bits,
                                input bit lsb, input int offset);
      cfg_en = 1'b0;
      stall  = 1'b0;
      ws     = 1'b0;
      repeat (3) @(negedge clk);
      feed_q.delete();
      exp_q.delete();
      cfg_num_lanes = LANE_W'(lanes - 1);
      cfg_num_slots = SLOT_W'(slots - 1);
      cfg_num_bits  = BIT_W'(bits - 1);
      cfg_lsb_first = lsb;
      cfg_offset    = 9'(offset);
`ifdef I2S_TX_SLOT_MASK_EN
      slot_mask = '1;
`endif
      @(negedge clk);
   endtask

   task automatic start_preload();
      int cycles;
      cycles = 0;
      cfg_en = 1'b1;
      while (!ready_to_send && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("preload_done", ready_to_send, 1);
   endtask

   task automatic push_frame_words(input int nslots, input int lanes, input int nb);
      logic [DW-1:0] mask;
      logic [DW-1:0] w;
      slot_t         e;
      mask = {DW{1'b1}} >> (DW - 1 - nb);
      for (int s = 0; s < nslots; s++) begin
         e = '0;
         for (int l = 0; l < lanes; l++) begin
            w = $urandom;
            feed_q.push_back(w);
            e.words[l] = w & mask;
         end
         exp_q.push_back(e);
      end
   endtask

   task automatic start_frame(input int offset, input bit chained);
      if (!chained) begin
         @(negedge clk);
         ws = 1'b1;
      end
      @(negedge clk);
      ws = 1'b0;
      for (int i = 0; i < offset; i++) begin
         checkOutput($sformatf("offset_quiet%0d", i), sd, 0);
         @(negedge clk);
      end
   endtask

   task automatic collect_frame(input int nslots, input int nb, input int lanes, input bit lsb,
                                input bit chain, input int mid_ws, input int release_slot);
      logic [NUM_LANES-1:0][DW-1:0] got;
      logic [NUM_LANES-1:0]         active_mask;
      int                           ur_count;
      logic                         stray;
      int                           idx;
      slot_t                        e;
      active_mask = NUM_LANES'((1 << lanes) - 1);
      for (int s = 0; s < nslots; s++) begin
         got      = '0;
         ur_count = 0;
         stray    = 1'b0;
         for (int b = 0; b <= nb; b++) begin
            if (s != 0 || b != 0) @(negedge clk);
            if (s == release_slot && b == 0) stall = 1'b0;
            if (s == 0 && b == mid_ws) ws = 1'b1;
            if (s == 0 && b == mid_ws + 1) ws = 1'b0;
            if (chain && s == nslots - 1 && b == nb) ws = 1'b1;
            idx = lsb ? b : nb - b;
            for (int l = 0; l < lanes; l++) got[l][idx] = sd[l];
            if ((sd & ~active_mask) != '0) stray = 1'b1;
            if (underrun) ur_count++;
         end
         if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            for (int l = 0; l < lanes; l++) begin
               checkOutput($sformatf("slot%0d_lane%0d", s, l), got[l], e.words[l]);
            end
            checkOutput($sformatf("slot%0d_underrun", s), ur_count, e.underrun);
            checkOutput($sformatf("slot%0d_inactive", s), stray, 0);
         end
      end
   endtask

   task automatic check_quiet(input string tag);
      checkOutput({tag, "_sd"}, sd, 0);
      checkOutput({tag, "_fifo_ready"}, fifo_if.ready, 0);
      checkOutput({tag, "_ready_to_send"}, ready_to_send, 0);
      checkOutput({tag, "_underrun"}, underrun, 0);
   endtask

   initial begin
      logic [DW-1:0] w[6];
      slot_t         e;
      rstn          = 1'b0;
      cfg_en        = 1'b0;
      ws            = 1'b0;
      stall         = 1'b0;
      cfg_num_lanes = '0;
      cfg_num_slots = '0;
      cfg_num_bits  = '0;
      cfg_lsb_first = 1'b0;
      cfg_offset    = '0;
`ifdef I2S_TX_SLOT_MASK_EN
      slot_mask = '1;
`endif
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rstn = 1'b1;

      $display("[TB] single lane, two 16-bit slots, MSB first, offset 0");
      applyStimulus(1, 2, 16, 1'b0, 0);
      feed_q.push_back(32'h0000A5A5);
      feed_q.push_back(32'hFFFF3C3C);
      e = '0; e.words[0] = 32'hA5A5; exp_q.push_back(e);
      e = '0; e.words[0] = 32'h3C3C; exp_q.push_back(e);
      start_preload();
      checkOutput("wait_fs_sd", sd, 0);
      start_frame(0, 1'b0);
      collect_frame(2, 15, 1, 1'b0, 1'b0, -1, -1);
      @(negedge clk);
      checkOutput("post_frame_sd", sd, 0);

      $display("[TB] two lanes, four 32-bit slots, offset 3");
      applyStimulus(2, 4, 32, 1'b0, 3);
      push_frame_words(4, 2, 31);
      start_preload();
      start_frame(3, 1'b0);
      collect_frame(4, 31, 2, 1'b0, 1'b0, -1, -1);

      $display("[TB] FIFO stalled for one slot");
      applyStimulus(2, 4, 8, 1'b0, 0);
      for (int i = 0; i < 6; i++) begin
         w[i] = $urandom;
         feed_q.push_back(w[i]);
      end
      e = '0; e.words[0] = w[0] & 32'hFF; e.words[1] = w[1] & 32'hFF; exp_q.push_back(e);
      e = '0; e.underrun = 1'b1; exp_q.push_back(e);
      e = '0; e.words[0] = w[2] & 32'hFF; e.words[1] = w[3] & 32'hFF; exp_q.push_back(e);
      e = '0; e.words[0] = w[4] & 32'hFF; e.words[1] = w[5] & 32'hFF; exp_q.push_back(e);
      start_preload();
      stall = 1'b1;
      start_frame(0, 1'b0);
      collect_frame(4, 7, 2, 1'b0, 1'b0, -1, 1);

      $display("[TB] back-to-back frames, LSB first, stray frame sync mid-frame");
      applyStimulus(2, 2, 8, 1'b1, 0);
      push_frame_words(2, 2, 7);
      push_frame_words(2, 2, 7);
      start_preload();
      start_frame(0, 1'b0);
      collect_frame(2, 7, 2, 1'b1, 1'b1, 3, -1);
      start_frame(0, 1'b1);
      collect_frame(2, 7, 2, 1'b1, 1'b0, -1, -1);
      @(negedge clk);
      checkOutput("after_chain_sd", sd, 0);

      $display("[TB] enable dropped mid-frame");
      applyStimulus(2, 4, 32, 1'b0, 0);
      push_frame_words(4, 2, 31);
      start_preload();
      start_frame(0, 1'b0);
      repeat (10) @(negedge clk);
      cfg_en = 1'b0;
      @(negedge clk);
      check_quiet("abort");

      $display("[TB] reset asserted mid-frame");
      applyStimulus(2, 4, 32, 1'b0, 0);
      push_frame_words(4, 2, 31);
      start_preload();
      start_frame(0, 1'b0);
      repeat (10) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check_quiet("midreset");
      rstn = 1'b1;

`ifdef I2S_TX_SLOT_MASK_EN
      $display("[TB] slot mask 0101 over four slots");
      applyStimulus(2, 4, 8, 1'b0, 0);
      slot_mask = 8'b0000_0101;
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         feed_q.push_back(w[i]);
      end
      e = '0; e.words[0] = w[0] & 32'hFF; e.words[1] = w[1] & 32'hFF; exp_q.push_back(e);
      e = '0; exp_q.push_back(e);
      e = '0; e.words[0] = w[2] & 32'hFF; e.words[1] = w[3] & 32'hFF; exp_q.push_back(e);
      e = '0; exp_q.push_back(e);
      start_preload();
      start_frame(0, 1'b0);
      collect_frame(4, 7, 2, 1'b0, 1'b0, -1, -1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
